axi_tdd_ng_sequencer: RTL and testbench

- Parametrised TDD timing core for the axi_tdd_ng family. Register-domain values (control, channel enable and polarity, burst count, startup delay, frame length, sync period, per-channel on/off) arrive already synchronised to clk.
- The core runs the IDLE/ARMED/WAITING/RUNNING frame sequencer. It drives up to 32 channel outputs with programmable on/off points.
- Additions over the previous generation:
  - width-generic counters
  - internal periodic sync generator
  - sync-reset (re-trigger) mode
  - on/off windows that wrap across a frame boundary

---
 rtl/axi_tdd_ng_sequencer.sv | 163 ++++++++++++++++
 tb/tb_axi_tdd_ng_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_tdd_ng_sequencer.sv
// TDD frame sequencer: IDLE/ARMED/WAITING/RUNNING state machine with up to 32
// programmable channel windows, internal periodic sync and sync-reset re-trigger.
module axi_tdd_ng_sequencer #(
   parameter int unsigned CHANNEL_COUNT = 8,
   parameter int unsigned REGISTER_WIDTH = 32,
   parameter int unsigned BURST_COUNT_WIDTH = 32,
   parameter int unsigned SYNC_COUNT_WIDTH = 64,
   parameter logic [CHANNEL_COUNT-1:0] DEFAULT_POLARITY = '0
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    tdd_enable,
   input  logic                                    tdd_sync_rst,
   input  logic                                    tdd_sync_int,
   input  logic                                    tdd_sync_ext,
   input  logic                                    tdd_sync_soft,
   input  logic                                    sync_in,
   input  logic [BURST_COUNT_WIDTH-1:0]            tdd_burst_count,
   input  logic [REGISTER_WIDTH-1:0]               tdd_startup_delay,
   input  logic [REGISTER_WIDTH-1:0]               tdd_frame_length,
   input  logic [SYNC_COUNT_WIDTH-1:0]             tdd_sync_period,
   input  logic [CHANNEL_COUNT-1:0]                tdd_channel_enable,
   input  logic [CHANNEL_COUNT-1:0]                tdd_channel_polarity,
   input  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0] tdd_channel_on,
   input  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0] tdd_channel_off,
   output logic [CHANNEL_COUNT-1:0]                tdd_channel,
   output logic [1:0]                              tdd_cstate,
   output logic                                    tdd_endof_frame,
   output logic                                    tdd_sync_out
);

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_ARMED   = 2'b01;
   localparam logic [1:0] ST_WAITING = 2'b10;
   localparam logic [1:0] ST_RUNNING = 2'b11;

   logic [1:0]                   state_q, state_d;
   logic [REGISTER_WIDTH-1:0]    delay_cnt_q, delay_cnt_d;
   logic [REGISTER_WIDTH-1:0]    frame_cnt_q, frame_cnt_d;
   logic [BURST_COUNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
   logic [SYNC_COUNT_WIDTH-1:0]  sync_cnt_q, sync_cnt_d;
   logic                         sync_in_q, sync_in_d;
   logic                         sync_out_q, sync_out_d;
   logic                         eof_q, eof_d;
   logic [CHANNEL_COUNT-1:0]     raw_q, raw_d;
   logic [CHANNEL_COUNT-1:0]     channel_q, channel_d;
   logic                         sync_acc;

   always_comb begin
      sync_acc = tdd_sync_soft
               | (tdd_sync_ext & sync_in & ~sync_in_q)
               | (tdd_sync_int & (sync_cnt_q == tdd_sync_period));
      sync_in_d  = sync_in;
      sync_out_d = sync_acc && (state_q != ST_IDLE);
      if (tdd_sync_int && (state_q != ST_IDLE))
         sync_cnt_d = (sync_cnt_q == tdd_sync_period) ? '0 : sync_cnt_q + SYNC_COUNT_WIDTH'(1);
      else
         sync_cnt_d = '0;
   end

   always_comb begin
      state_d     = state_q;
      delay_cnt_d = delay_cnt_q;
      frame_cnt_d = frame_cnt_q;
      burst_cnt_d = burst_cnt_q;
      if (!tdd_enable) begin
         state_d     = ST_IDLE;
         delay_cnt_d = '0;
         frame_cnt_d = '0;
         burst_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d     = ST_ARMED;
               burst_cnt_d = '0;
            end
            ST_ARMED: begin
               if (sync_acc) begin
                  state_d     = ST_WAITING;
                  delay_cnt_d = '0;
                  frame_cnt_d = '0;
               end
            end
            default: begin
               // Re-trigger outranks both the delay expiry and the frame-end transition
               if (sync_acc && tdd_sync_rst) begin
                  state_d     = ST_WAITING;
                  delay_cnt_d = '0;
                  frame_cnt_d = '0;
                  burst_cnt_d = '0;
               end else if (state_q == ST_WAITING) begin
                  if (delay_cnt_q == tdd_startup_delay) begin
                     state_d     = ST_RUNNING;
                     frame_cnt_d = '0;
                  end else begin
                     delay_cnt_d = delay_cnt_q + REGISTER_WIDTH'(1);
                  end
               end else if (frame_cnt_q == tdd_frame_length) begin
                  frame_cnt_d = '0;
                  if ((tdd_burst_count != '0) &&
                      (burst_cnt_q + BURST_COUNT_WIDTH'(1) == tdd_burst_count)) begin
                     state_d     = ST_ARMED;
                     burst_cnt_d = '0;
                  end else if (burst_cnt_q != '1) begin
                     burst_cnt_d = burst_cnt_q + BURST_COUNT_WIDTH'(1);
                  end
               end else begin
                  frame_cnt_d = frame_cnt_q + REGISTER_WIDTH'(1);
               end
            end
         endcase
      end
      // Registered from the next-state compare so the pulse lines up with the last frame cycle
      eof_d = (state_d == ST_RUNNING) && (frame_cnt_d == tdd_frame_length);
   end

   always_comb begin
      raw_d = raw_q;
      for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
         if ((state_d != ST_RUNNING) || !tdd_channel_enable[i])
            raw_d[i] = 1'b0;
         else if ((state_q == ST_RUNNING) &&
                  (frame_cnt_q == tdd_channel_off[i*REGISTER_WIDTH +: REGISTER_WIDTH]))
            raw_d[i] = 1'b0;
         else if ((state_q == ST_RUNNING) &&
                  (frame_cnt_q == tdd_channel_on[i*REGISTER_WIDTH +: REGISTER_WIDTH]))
            raw_d[i] = 1'b1;
      end
      channel_d = raw_d ^ tdd_channel_polarity;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         delay_cnt_q <= '0;
         frame_cnt_q <= '0;
         burst_cnt_q <= '0;
         sync_cnt_q  <= '0;
         sync_in_q   <= 1'b0;
         sync_out_q  <= 1'b0;
         eof_q       <= 1'b0;
         raw_q       <= '0;
         channel_q   <= DEFAULT_POLARITY;
      end else begin
         state_q     <= state_d;
         delay_cnt_q <= delay_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         sync_cnt_q  <= sync_cnt_d;
         sync_in_q   <= sync_in_d;
         sync_out_q  <= sync_out_d;
         eof_q       <= eof_d;
         raw_q       <= raw_d;
         channel_q   <= channel_d;
      end
   end

   assign tdd_channel     = channel_q;
   assign tdd_cstate      = state_q;
   assign tdd_endof_frame = eof_q;
   assign tdd_sync_out    = sync_out_q;

endmodule

// File: tb/tb_axi_tdd_ng_sequencer.sv
// Directed bench for axi_tdd_ng_sequencer: burst timing, wrapping windows,
// sync re-trigger, enable drop, async reset and internal sync generator.
module tb_axi_tdd_ng_sequencer;

   localparam int CC = 8;
   localparam int RW = 32;
   localparam int BW = 32;
   localparam int SW = 64;
   localparam logic [CC-1:0] DEF_POL = 8'h5A;

   logic clk = 1'b0;
   logic rst;
   logic tdd_enable, tdd_sync_rst, tdd_sync_int, tdd_sync_ext, tdd_sync_soft, sync_in;
   logic [BW-1:0]    tdd_burst_count;
   logic [RW-1:0]    tdd_startup_delay, tdd_frame_length;
   logic [SW-1:0]    tdd_sync_period;
   logic [CC-1:0]    tdd_channel_enable, tdd_channel_polarity;
   logic [CC*RW-1:0] tdd_channel_on, tdd_channel_off;
   logic [CC-1:0]    tdd_channel;
   logic [1:0]       tdd_cstate;
   logic             tdd_endof_frame, tdd_sync_out;

   int total = 0;
   int bad = 0;
   int gap;

   axi_tdd_ng_sequencer #(
      .CHANNEL_COUNT(CC),
      .REGISTER_WIDTH(RW),
      .BURST_COUNT_WIDTH(BW),
      .SYNC_COUNT_WIDTH(SW),
      .DEFAULT_POLARITY(DEF_POL)
   ) dut (
      .clk(clk), .rst(rst),
      .tdd_enable(tdd_enable), .tdd_sync_rst(tdd_sync_rst),
      .tdd_sync_int(tdd_sync_int), .tdd_sync_ext(tdd_sync_ext),
      .tdd_sync_soft(tdd_sync_soft), .sync_in(sync_in),
      .tdd_burst_count(tdd_burst_count), .tdd_startup_delay(tdd_startup_delay),
      .tdd_frame_length(tdd_frame_length), .tdd_sync_period(tdd_sync_period),
      .tdd_channel_enable(tdd_channel_enable), .tdd_channel_polarity(tdd_channel_polarity),
      .tdd_channel_on(tdd_channel_on), .tdd_channel_off(tdd_channel_off),
      .tdd_channel(tdd_channel), .tdd_cstate(tdd_cstate),
      .tdd_endof_frame(tdd_endof_frame), .tdd_sync_out(tdd_sync_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_pt(input int ch, input logic [RW-1:0] on, input logic [RW-1:0] off);
      tdd_channel_on[ch*RW +: RW]  = on;
      tdd_channel_off[ch*RW +: RW] = off;
   endtask

   // ch0 window 2..5 (seen 3..5), ch1 wrapping window 8..2 (seen 9..2 once armed), ch2/ch3 never on
   function automatic logic [CC-1:0] exp_wrap(input int k);
      int m;
      logic b0, b1;
      m  = k % 10;
      b0 = (m >= 3) && (m <= 5);
      b1 = (k >= 9) && ((m >= 9) || (m <= 2));
      return {6'b0, b1, b0};
   endfunction

   initial begin
      rst = 1'b1;
      tdd_enable = 0; tdd_sync_rst = 0; tdd_sync_int = 0; tdd_sync_ext = 0;
      tdd_sync_soft = 0; sync_in = 0;
      tdd_burst_count = 2; tdd_startup_delay = 3; tdd_frame_length = 9;
      tdd_sync_period = 99;
      tdd_channel_enable = 8'h01; tdd_channel_polarity = 8'h00;
      tdd_channel_on = '0; tdd_channel_off = '0;
      set_pt(0, 2, 5);

      step();
      chk("rst_channel", tdd_channel, DEF_POL);
      chk("rst_cstate", tdd_cstate, 2'b00);
      chk("rst_eof", tdd_endof_frame, 1'b0);
      chk("rst_sync_out", tdd_sync_out, 1'b0);

      // Burst of two 10-cycle frames, startup delay 3
      tdd_enable = 1; rst = 0;
      step();
      chk("armed", tdd_cstate, 2'b01);
      chk("armed_channel", tdd_channel, 8'h00);
      tdd_sync_soft = 1;
      step();
      tdd_sync_soft = 0;
      chk("soft_waiting", tdd_cstate, 2'b10);
      chk("soft_sync_out", tdd_sync_out, 1'b1);
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("wait_state", tdd_cstate, 2'b10);
         if (i == 1) chk("sync_out_once", tdd_sync_out, 1'b0);
      end
      for (int k = 0; k < 20; k++) begin
         step();
         chk("b1_state", tdd_cstate, 2'b11);
         chk("b1_channel", tdd_channel, {7'b0, ((k % 10) >= 3) && ((k % 10) <= 5)});
         chk("b1_eof", tdd_endof_frame, (k % 10) == 9);
      end
      step();
      chk("burst_end_armed", tdd_cstate, 2'b01);
      chk("burst_end_channel", tdd_channel, 8'h00);
      chk("burst_end_eof", tdd_endof_frame, 1'b0);
      step();
      chk("armed_hold", tdd_cstate, 2'b01);

      // Infinite burst, wrapping ch1, degenerate ch2/ch3
      tdd_burst_count = 0;
      tdd_channel_enable = 8'h0F;
      set_pt(1, 8, 2);
      set_pt(2, 4, 4);
      set_pt(3, 20, 1);
      tdd_sync_ext = 1;
      tdd_sync_soft = 1;
      step();
      tdd_sync_soft = 0;
      chk("b2_waiting", tdd_cstate, 2'b10);
      for (int i = 0; i < 3; i++) step();
      for (int k = 0; k < 35; k++) begin
         step();
         chk("wrap_state", tdd_cstate, 2'b11);
         chk("wrap_channel", tdd_channel, exp_wrap(k));
      end
      // External edge at frame_cnt 4 without re-trigger: pulse only
      sync_in = 1;
      step();
      chk("ext_ignored_sync_out", tdd_sync_out, 1'b1);
      chk("ext_ignored_state", tdd_cstate, 2'b11);
      chk("ext_ignored_channel", tdd_channel, exp_wrap(35));
      for (int k = 36; k < 40; k++) begin
         step();
         chk("wrap2_channel", tdd_channel, exp_wrap(k));
      end
      sync_in = 0;
      for (int k = 40; k < 45; k++) begin
         step();
         chk("wrap3_channel", tdd_channel, exp_wrap(k));
         chk("wrap3_eof", tdd_endof_frame, (k % 10) == 9);
      end
      // Same edge with re-trigger enabled
      sync_in = 1; tdd_sync_rst = 1;
      step();
      chk("retrig_state", tdd_cstate, 2'b10);
      chk("retrig_sync_out", tdd_sync_out, 1'b1);
      chk("retrig_channel", tdd_channel, 8'h00);
      chk("retrig_eof", tdd_endof_frame, 1'b0);
      tdd_sync_rst = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("retrig_wait", tdd_cstate, 2'b10);
         chk("retrig_wait_channel", tdd_channel, 8'h00);
      end
      for (int k = 0; k < 15; k++) begin
         step();
         chk("restart_state", tdd_cstate, 2'b11);
         chk("restart_channel", tdd_channel, exp_wrap(k));
         chk("restart_eof", tdd_endof_frame, (k % 10) == 9);
      end

      // Enable drop mid-frame with polarity
      tdd_enable = 0; tdd_channel_polarity = 8'h03;
      step();
      chk("disable_idle", tdd_cstate, 2'b00);
      chk("disable_channel", tdd_channel, 8'h03);
      step();
      chk("idle_hold", tdd_cstate, 2'b00);
      chk("idle_channel", tdd_channel, 8'h03);

      // Async reset mid-frame
      tdd_channel_polarity = 8'h00; tdd_enable = 1; sync_in = 0;
      step();
      tdd_sync_soft = 1;
      step();
      tdd_sync_soft = 0;
      for (int i = 0; i < 9; i++) step();
      chk("pre_rst_running", tdd_cstate, 2'b11);
      tdd_sync_int = 1; tdd_burst_count = 1; tdd_channel_enable = 8'h01;
      #2 rst = 1;
      #1;
      chk("async_rst_channel", tdd_channel, DEF_POL);
      chk("async_rst_cstate", tdd_cstate, 2'b00);
      chk("async_rst_eof", tdd_endof_frame, 1'b0);
      step();
      rst = 0;

      // Internal sync generator, period 100, single-frame bursts
      step();
      chk("int_armed", tdd_cstate, 2'b01);
      gap = 0;
      do begin
         step();
         gap++;
      end while (!tdd_sync_out && gap < 150);
      chk("int_first_gap", gap, 100);
      chk("int_first_state", tdd_cstate, 2'b10);
      for (int rep = 0; rep < 2; rep++) begin
         for (int j = 1; j <= 14; j++) begin
            step();
            if (j == 13) begin
               chk("int_eof", tdd_endof_frame, 1'b1);
               chk("int_running", tdd_cstate, 2'b11);
            end
            if (j == 14) chk("int_rearmed", tdd_cstate, 2'b01);
         end
         gap = 14;
         do begin
            step();
            gap++;
         end while (!tdd_sync_out && gap < 150);
         chk("int_period", gap, 100);
         chk("int_sync_state", tdd_cstate, 2'b10);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
